// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state type and baud sizing helpers for the uart0 receive path
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  // Count loaded on the start edge so the first sample lands mid start bit.
  function automatic int half_bit_count(input int clks_per_bit);
    return clks_per_bit / 2 - 1;
  endfunction

  // Width of a counter that must hold values 0 .. clks_per_bit-1.
  function automatic int baud_cnt_width(input int clks_per_bit);
    return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_deser.sv
// rtl/uart_rx_deser.sv - rx synchronizer and 8N1 deserializer FSM (8E1 with UART_RX_PARITY_EN)
module uart_rx_deser
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       resetq,
  input  logic       rx,
  output logic       byte_stb,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

  localparam int            BW        = baud_cnt_width(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_HALF = BW'(half_bit_count(CLKS_PER_BIT));
  localparam logic [BW-1:0] BAUD_FULL = BW'(CLKS_PER_BIT - 1);

  rx_state_t     state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          brk_q, brk_d;
  logic          ferr_q, ferr_d;
  logic          rx_meta_q, rx_s_q;
  logic          stb;
  logic          sample;
`ifdef UART_RX_PARITY_EN
  logic          par_err_q, par_err_d;
`endif

  assign sample    = (baud_q == '0);
  assign byte_stb  = stb;
  assign rx_byte   = shift_q;
  assign frame_err = ferr_q;

  // Two-flop synchronizer; resets to the idle line level.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Frame sequencing: mid-bit sampling, LSB-first shift, stop/break handling.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    brk_d   = brk_q;
    ferr_d  = 1'b0;
    stb     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d = par_err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          baud_d  = BAUD_HALF;
        end
      end
      START: begin
        if (!sample) begin
          baud_d = baud_q - 1'b1;
        end else if (rx_s_q) begin
          state_d = IDLE;
        end else begin
          state_d = DATA;
          baud_d  = BAUD_FULL;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (!sample) begin
          baud_d = baud_q - 1'b1;
        end else begin
          shift_d = {rx_s_q, shift_q[7:1]};
          baud_d  = BAUD_FULL;
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (!sample) begin
          baud_d = baud_q - 1'b1;
        end else begin
          par_err_d = ^{shift_q, rx_s_q};
          baud_d    = BAUD_FULL;
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        if (brk_q) begin
          // Line held low after a bad stop bit: wait for idle before rearming.
          if (rx_s_q) begin
            brk_d   = 1'b0;
            state_d = IDLE;
          end
        end else if (!sample) begin
          baud_d = baud_q - 1'b1;
        end else if (!rx_s_q) begin
          ferr_d = 1'b1;
          brk_d  = 1'b1;
        end else begin
          state_d = IDLE;
`ifdef UART_RX_PARITY_EN
          if (par_err_q) ferr_d = 1'b1;
          else           stb    = 1'b1;
`else
          stb = 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and registered error pulse.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      brk_q   <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      brk_q   <= brk_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_err_q <= par_err_d;
`endif
    end
  end

endmodule

// File: rtl/uart0_rx_fifo.sv
// rtl/uart0_rx_fifo.sv - uart0 receive front end: deserializer, byte FIFO, overrun counter (option UART_RX_PARITY_EN)
module uart0_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DEPTH_LOG2   = 4
) (
  input  logic       clk,
  input  logic       resetq,
  input  logic       rx,
  input  logic       uart0_rd,
  output logic       uart0_valid,
  output logic [7:0] uart0_data,
  output logic       frame_err,
  output logic [7:0] drop_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic                byte_stb;
  logic [7:0]          rx_byte;
  logic [7:0]          mem_q [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0]          drop_q, drop_d;
  logic                empty, full, do_pop, do_push;

  uart_rx_deser #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_deser (
    .clk       (clk),
    .resetq    (resetq),
    .rx        (rx),
    .byte_stb  (byte_stb),
    .rx_byte   (rx_byte),
    .frame_err (frame_err)
  );

  // Occupancy decode, push/pop arbitration and saturating overrun count.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = ((wr_ptr_q - rd_ptr_q) == (DEPTH_LOG2 + 1)'(DEPTH));
    do_pop   = uart0_rd && !empty;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    do_push  = byte_stb && (!full || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    drop_d   = drop_q;
    if (byte_stb && !do_push && (drop_q != 8'hFF)) drop_d = drop_q + 1'b1;
  end

  // Byte storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= rx_byte;
  end

  // Pointers and drop counter.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      drop_q   <= drop_d;
    end
  end

  assign uart0_valid = !empty;
  assign uart0_data  = empty ? 8'h00 : mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
  assign drop_count  = drop_q;

endmodule

// File: tb/tb_uart0_rx_fifo.sv
// tb/tb_uart0_rx_fifo.sv - self-checking bench for uart0_rx_fifo against a queue model
`timescale 1ns/1ps
module tb_uart0_rx_fifo;

  localparam int CPB   = 16;
  localparam int DLOG  = 4;
  localparam int DEPTH = 1 << DLOG;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  // Edges from the start-bit transition to the push edge: two synchronizer
  // flops, one edge leaving IDLE, half a bit to the start-bit centre, then one
  // full bit per remaining frame bit up to the stop-bit centre.
  localparam int LAT = 3 + CPB / 2 + (FRAME_BITS - 1) * CPB;

  logic       clk = 1'b0;
  logic       resetq = 1'b0;
  logic       rx = 1'b1;
  logic       uart0_rd = 1'b0;
  logic       uart0_valid;
  logic [7:0] uart0_data;
  logic       frame_err;
  logic [7:0] drop_count;

  int         n_cmp = 0;
  int         n_err = 0;
  int         fe_cnt = 0;
  logic [7:0] exp_q[$];
  int         exp_drop = 0;

  uart0_rx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH_LOG2(DLOG)) dut (
    .clk         (clk),
    .resetq      (resetq),
    .rx          (rx),
    .uart0_rd    (uart0_rd),
    .uart0_valid (uart0_valid),
    .uart0_data  (uart0_data),
    .frame_err   (frame_err),
    .drop_count  (drop_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_err === 1'b1) fe_cnt++;

  function automatic void model_rx(input logic [7:0] b);
    if (exp_q.size() < DEPTH) exp_q.push_back(b);
    else if (exp_drop < 255) exp_drop++;
  endfunction

  // Drives one frame bit-by-bit; optionally pops at step pop_cyc and reports
  // the first edge (counted from the start bit) after which uart0_valid was 1.
  task automatic send_frame(input logic [7:0] b, input logic par_bad, input int stop_low,
                            input int pop_cyc, output logic [7:0] pop_data, output int first_v);
    logic lvl[$];
    lvl.push_back(1'b0);
    for (int i = 0; i < 8; i++) lvl.push_back(b[i]);
`ifdef UART_RX_PARITY_EN
    lvl.push_back((^b) ^ par_bad);
`endif
    repeat (stop_low) lvl.push_back(1'b0);
    lvl.push_back(1'b1);
    pop_data = 8'h00;
    first_v  = -1;
    for (int c = 0; c < lvl.size() * CPB; c++) begin
      rx = lvl[c / CPB];
      if (c == pop_cyc) begin
        uart0_rd = 1'b1;
        pop_data = uart0_data;
      end else begin
        uart0_rd = 1'b0;
      end
      @(posedge clk); #1;
      if (first_v < 0 && uart0_valid === 1'b1) first_v = c + 1;
    end
    uart0_rd = 1'b0;
    rx = 1'b1;
  endtask

  task automatic do_pop(output logic v, output logic [7:0] d);
    v = uart0_valid;
    d = uart0_data;
    uart0_rd = 1'b1;
    @(posedge clk); #1;
    uart0_rd = 1'b0;
  endtask

  task automatic test_reset;
    resetq = 1'b0; rx = 1'b1; uart0_rd = 1'b0;
    repeat (3) @(posedge clk); #1;
    n_cmp++; if (uart0_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", uart0_valid); end
    n_cmp++; if (uart0_data !== 8'h00) begin n_err++; $display("FAIL reset_data got %h want 00", uart0_data); end
    n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
    n_cmp++; if (drop_count !== 8'h00) begin n_err++; $display("FAIL reset_drop got %h want 00", drop_count); end
    resetq = 1'b1;
    repeat (2 * CPB) @(posedge clk); #1;
    n_cmp++; if (uart0_valid !== 1'b0) begin n_err++; $display("FAIL idle_valid got %b want 0", uart0_valid); end
  endtask

  task automatic test_single_byte;
    logic [7:0] pd, d;
    logic v;
    int fv;
    send_frame(8'h41, 1'b0, 0, -1, pd, fv);
    model_rx(8'h41);
    n_cmp++; if (fv !== LAT) begin n_err++; $display("FAIL single_latency got %0d want %0d", fv, LAT); end
    n_cmp++; if (uart0_data !== 8'h41) begin n_err++; $display("FAIL single_data got %h want 41", uart0_data); end
    do_pop(v, d);
    void'(exp_q.pop_front());
    n_cmp++; if (uart0_valid !== 1'b0) begin n_err++; $display("FAIL single_pop_valid got %b want 0", uart0_valid); end
  endtask

  task automatic test_overrun_burst;
    logic [7:0] pd, d, e;
    logic v;
    int fv;
    for (int i = 0; i <= DEPTH; i++) begin
      send_frame(8'(i), 1'b0, 0, -1, pd, fv);
      model_rx(8'(i));
    end
    n_cmp++; if (drop_count !== 8'(exp_drop)) begin n_err++; $display("FAIL burst_drop got %0d want %0d", drop_count, exp_drop); end
    for (int i = 0; i < DEPTH; i++) begin
      e = exp_q.pop_front();
      do_pop(v, d);
      n_cmp++; if (v !== 1'b1 || d !== e) begin n_err++; $display("FAIL burst_pop%0d got v=%b d=%h want v=1 d=%h", i, v, d, e); end
    end
    n_cmp++; if (uart0_valid !== 1'b0) begin n_err++; $display("FAIL burst_empty got %b want 0", uart0_valid); end
  endtask

  task automatic test_bad_stop;
    logic [7:0] pd, d;
    logic v;
    int fv, fe0;
    fe0 = fe_cnt;
    send_frame(8'h55, 1'b0, 3, -1, pd, fv);
    repeat (4) @(posedge clk); #1;
    n_cmp++; if (fe_cnt - fe0 !== 1) begin n_err++; $display("FAIL badstop_pulses got %0d want 1", fe_cnt - fe0); end
    n_cmp++; if (uart0_valid !== 1'b0) begin n_err++; $display("FAIL badstop_valid got %b want 0", uart0_valid); end
    send_frame(8'hAA, 1'b0, 0, -1, pd, fv);
    model_rx(8'hAA);
    n_cmp++; if (uart0_valid !== 1'b1 || uart0_data !== 8'hAA) begin n_err++; $display("FAIL after_break got v=%b d=%h want v=1 d=aa", uart0_valid, uart0_data); end
    do_pop(v, d);
    void'(exp_q.pop_front());
  endtask

  task automatic test_start_glitch;
    logic [7:0] pd, d, b;
    logic v;
    int fv, fe0;
    fe0 = fe_cnt;
    rx = 1'b0;
    repeat (4) @(posedge clk); #1;
    rx = 1'b1;
    repeat (2 * CPB) @(posedge clk); #1;
    n_cmp++; if (uart0_valid !== 1'b0) begin n_err++; $display("FAIL glitch_valid got %b want 0", uart0_valid); end
    n_cmp++; if (fe_cnt !== fe0) begin n_err++; $display("FAIL glitch_ferr got %0d want %0d", fe_cnt, fe0); end
    b = 8'($urandom);
    send_frame(b, 1'b0, 0, -1, pd, fv);
    model_rx(b);
    n_cmp++; if (fv !== LAT || uart0_data !== b) begin n_err++; $display("FAIL glitch_next got lat=%0d d=%h want lat=%0d d=%h", fv, uart0_data, LAT, b); end
    do_pop(v, d);
    void'(exp_q.pop_front());
  endtask

  task automatic test_full_simul_pop;
    logic [7:0] pd, d, e, b;
    logic v;
    int fv;
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom);
      send_frame(b, 1'b0, 0, -1, pd, fv);
      model_rx(b);
    end
    b = 8'($urandom);
    send_frame(b, 1'b0, 0, LAT - 1, pd, fv);
    e = exp_q.pop_front();
    model_rx(b);
    n_cmp++; if (pd !== e) begin n_err++; $display("FAIL full_pop_data got %h want %h", pd, e); end
    n_cmp++; if (drop_count !== 8'(exp_drop)) begin n_err++; $display("FAIL full_drop got %0d want %0d", drop_count, exp_drop); end
    for (int i = 0; i < DEPTH; i++) begin
      e = exp_q.pop_front();
      do_pop(v, d);
      n_cmp++; if (v !== 1'b1 || d !== e) begin n_err++; $display("FAIL full_pop%0d got v=%b d=%h want v=1 d=%h", i, v, d, e); end
    end
    n_cmp++; if (uart0_valid !== 1'b0) begin n_err++; $display("FAIL full_empty got %b want 0", uart0_valid); end
  endtask

  task automatic test_random;
    logic [7:0] pd, d, b, e;
    logic v;
    int fv, np;
    for (int it = 0; it < 24; it++) begin
      b = 8'($urandom);
      send_frame(b, 1'b0, 0, -1, pd, fv);
      model_rx(b);
      np = $urandom_range(0, 2);
      for (int k = 0; k < np; k++) begin
        do_pop(v, d);
        if (exp_q.size() == 0) begin
          n_cmp++; if (v !== 1'b0) begin n_err++; $display("FAIL rand_empty it%0d got v=%b want 0", it, v); end
        end else begin
          e = exp_q.pop_front();
          n_cmp++; if (v !== 1'b1 || d !== e) begin n_err++; $display("FAIL rand_pop it%0d got v=%b d=%h want v=1 d=%h", it, v, d, e); end
        end
      end
    end
    n_cmp++; if (drop_count !== 8'(exp_drop)) begin n_err++; $display("FAIL rand_drop got %0d want %0d", drop_count, exp_drop); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      do_pop(v, d);
      n_cmp++; if (v !== 1'b1 || d !== e) begin n_err++; $display("FAIL rand_drain got v=%b d=%h want v=1 d=%h", v, d, e); end
    end
  endtask

  task automatic test_reset_midframe;
    logic [7:0] pd, d, b;
    logic v;
    int fv, fe0;
    send_frame(8'h5A, 1'b0, 0, -1, pd, fv);
    model_rx(8'h5A);
    b = 8'h3C;
    // Stop in the middle of data bit 4 (frame bit 5).
    for (int c = 0; c < 5 * CPB + CPB / 2; c++) begin
      rx = (c < CPB) ? 1'b0 : b[c / CPB - 1];
      @(posedge clk); #1;
    end
    resetq = 1'b0;
    #1;
    n_cmp++; if (uart0_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid got %b want 0", uart0_valid); end
    n_cmp++; if (uart0_data !== 8'h00) begin n_err++; $display("FAIL midrst_data got %h want 00", uart0_data); end
    n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL midrst_ferr got %b want 0", frame_err); end
    n_cmp++; if (drop_count !== 8'h00) begin n_err++; $display("FAIL midrst_drop got %h want 00", drop_count); end
    exp_q.delete();
    exp_drop = 0;
    rx = 1'b1;
    repeat (4) @(posedge clk); #1;
    resetq = 1'b1;
    repeat (2 * CPB) @(posedge clk); #1;
    fe0 = fe_cnt;
    send_frame(8'hC3, 1'b1, 0, -1, pd, fv);
    repeat (2) @(posedge clk); #1;
`ifdef UART_RX_PARITY_EN
    n_cmp++; if (fe_cnt - fe0 !== 1) begin n_err++; $display("FAIL parity_ferr got %0d want 1", fe_cnt - fe0); end
    n_cmp++; if (uart0_valid !== 1'b0) begin n_err++; $display("FAIL parity_valid got %b want 0", uart0_valid); end
`else
    model_rx(8'hC3);
    n_cmp++; if (uart0_valid !== 1'b1 || uart0_data !== 8'hC3) begin n_err++; $display("FAIL midrst_next got v=%b d=%h want v=1 d=c3", uart0_valid, uart0_data); end
    n_cmp++; if (fe_cnt !== fe0) begin n_err++; $display("FAIL midrst_next_ferr got %0d want %0d", fe_cnt, fe0); end
    do_pop(v, d);
    void'(exp_q.pop_front());
`endif
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_overrun_burst();
    test_bad_stop();
    test_start_glitch();
    test_full_simul_pop();
    test_random();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
